// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - access size encodings, IO window default and lane helpers for the MEM stage
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_size_e;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hffff_ff00;

    function automatic logic [3:0] lane_we(input mem_size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

    // Replicate the store data so every candidate lane carries the low bits.
    function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_e size,
                                                input logic [1:0] addr_lo, input logic zero_ext);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {addr_lo, 3'b000});
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: return zero_ext ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return zero_ext ? {16'b0, h} : {{16{h[15]}}, h};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - four byte-lane data memory with per-lane write enable and asynchronous read
module byte_ram #(
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [3:0]           we,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    // Contents come up zero from the configuration image; there is no reset port.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we[g]) begin
                lane_mem[addr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = lane_mem[addr];
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM stage with byte-addressed RAM, GPIO bank and registered WB outputs
module memory_stage
    import mem_pkg::*;
#(
    parameter int          ADDR_SIZE  = 10,
    parameter int          GPIO_COUNT = 4,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_mem,
    input  logic [31:0]             alu_data_mem,
    input  logic [31:0]             reg_t_data_mem,
    input  logic                    mem_we_mem,
    input  logic [1:0]              mem_size_mem,
    input  logic                    mem_unsigned_mem,
    input  logic                    reg_d_we_mem,
    input  logic [4:0]              reg_d_addr_mem,
    input  logic                    reg_d_data_sel_mem,
    input  logic [32*GPIO_COUNT-1:0] gpio_in,
    output logic [32*GPIO_COUNT-1:0] gpio_out,
    output logic [31:0]             alu_data_wb,
    output logic [31:0]             mem_data_wb,
    output logic                    reg_d_we_wb,
    output logic [4:0]              reg_d_addr_wb,
    output logic                    reg_d_data_sel_wb,
    output logic                    misaligned_wb
);

    mem_size_e            size;
    logic                 io_sel;
    logic [5:0]           ch;
    logic                 misaligned;
    logic                 wr_en;
    logic [ADDR_SIZE-1:0] word_idx;
    logic [3:0]           ram_we;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_rdata;
    logic [31:0]          io_rdata;
    logic [31:0]          load_data;
    logic [31:0]          sync1 [GPIO_COUNT];
    logic [31:0]          sync2 [GPIO_COUNT];

    assign size       = mem_size_e'(mem_size_mem);
    assign io_sel     = alu_data_mem[31:8] == IO_BASE[31:8];
    assign ch         = alu_data_mem[7:2];
    assign word_idx   = alu_data_mem[ADDR_SIZE+1:2];
    assign misaligned = is_misaligned(size, alu_data_mem[1:0]);
    assign wr_en      = mem_we_mem & ~stall_mem & ~misaligned & ~rst;
    assign ram_we     = (wr_en & ~io_sel) ? lane_we(size, alu_data_mem[1:0]) : 4'b0000;
    assign ram_wdata  = store_lanes(size, reg_t_data_mem);

    byte_ram #(
        .ADDR_SIZE(ADDR_SIZE)
    ) u_ram (
        .clk  (clk),
        .addr (word_idx),
        .we   (ram_we),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Channels beyond GPIO_COUNT never match, so they read as zero and ignore writes.
    always_comb begin
        io_rdata = 32'b0;
        for (int n = 0; n < GPIO_COUNT; n++) begin
            if (ch == 6'(n)) begin
                io_rdata = sync2[n];
            end
        end
    end

    assign load_data = load_extend(io_sel ? io_rdata : ram_rdata, size,
                                   alu_data_mem[1:0], mem_unsigned_mem);

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= '0;
        end else if (wr_en && io_sel) begin
            for (int n = 0; n < GPIO_COUNT; n++) begin
                if (ch == 6'(n)) begin
                    gpio_out[32*n +: 32] <= reg_t_data_mem;
                end
            end
        end
    end

    // Two-flop synchroniser per input bit; runs through stalls.
    always_ff @(posedge clk) begin
        for (int n = 0; n < GPIO_COUNT; n++) begin
            if (rst) begin
                sync1[n] <= 32'b0;
                sync2[n] <= 32'b0;
            end else begin
                sync1[n] <= gpio_in[32*n +: 32];
                sync2[n] <= sync1[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_data_wb       <= 32'b0;
            mem_data_wb       <= 32'b0;
            reg_d_we_wb       <= 1'b0;
            reg_d_addr_wb     <= 5'b0;
            reg_d_data_sel_wb <= 1'b0;
            misaligned_wb     <= 1'b0;
        end else if (!stall_mem) begin
            alu_data_wb       <= alu_data_mem;
            mem_data_wb       <= load_data;
            reg_d_we_wb       <= reg_d_we_mem & ~misaligned;
            reg_d_addr_wb     <= reg_d_addr_mem;
            reg_d_data_sel_wb <= reg_d_data_sel_mem;
            misaligned_wb     <= misaligned;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage against a byte-level model
module tb_memory_stage;

    localparam int ADDR_SIZE  = 10;
    localparam int GPIO_COUNT = 4;
    localparam int MEM_BYTES  = 4 << ADDR_SIZE;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem;
    logic [31:0] alu_data_mem;
    logic [31:0] reg_t_data_mem;
    logic        mem_we_mem;
    logic [1:0]  mem_size_mem;
    logic        mem_unsigned_mem;
    logic        reg_d_we_mem;
    logic [4:0]  reg_d_addr_mem;
    logic        reg_d_data_sel_mem;
    logic [32*GPIO_COUNT-1:0] gpio_in;
    logic [32*GPIO_COUNT-1:0] gpio_out;
    logic [31:0] alu_data_wb;
    logic [31:0] mem_data_wb;
    logic        reg_d_we_wb;
    logic [4:0]  reg_d_addr_wb;
    logic        reg_d_data_sel_wb;
    logic        misaligned_wb;

    logic [31:0] gin [GPIO_COUNT];
    assign gpio_in = {gin[3], gin[2], gin[1], gin[0]};

    always #5 clk = ~clk;

    memory_stage #(
        .ADDR_SIZE (ADDR_SIZE),
        .GPIO_COUNT(GPIO_COUNT),
        .IO_BASE   (32'hffff_ff00)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_mem         (stall_mem),
        .alu_data_mem      (alu_data_mem),
        .reg_t_data_mem    (reg_t_data_mem),
        .mem_we_mem        (mem_we_mem),
        .mem_size_mem      (mem_size_mem),
        .mem_unsigned_mem  (mem_unsigned_mem),
        .reg_d_we_mem      (reg_d_we_mem),
        .reg_d_addr_mem    (reg_d_addr_mem),
        .reg_d_data_sel_mem(reg_d_data_sel_mem),
        .gpio_in           (gpio_in),
        .gpio_out          (gpio_out),
        .alu_data_wb       (alu_data_wb),
        .mem_data_wb       (mem_data_wb),
        .reg_d_we_wb       (reg_d_we_wb),
        .reg_d_addr_wb     (reg_d_addr_wb),
        .reg_d_data_sel_wb (reg_d_data_sel_wb),
        .misaligned_wb     (misaligned_wb)
    );

    // Reference state: byte-array memory, GPIO registers and input samples from past edges.
    logic [7:0]  mb     [MEM_BYTES];
    logic [31:0] gout_m [GPIO_COUNT];
    logic [31:0] s1_m   [GPIO_COUNT];
    logic [31:0] s2_m   [GPIO_COUNT];
    logic [31:0] exp_alu, exp_mem;
    logic        exp_we, exp_sel, exp_mis;
    logic [4:0]  exp_addr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("alu_data_wb", alu_data_wb, exp_alu);
        check("mem_data_wb", mem_data_wb, exp_mem);
        check("reg_d_we_wb", 32'(reg_d_we_wb), 32'(exp_we));
        check("reg_d_addr_wb", 32'(reg_d_addr_wb), 32'(exp_addr));
        check("reg_d_data_sel_wb", 32'(reg_d_data_sel_wb), 32'(exp_sel));
        check("misaligned_wb", 32'(misaligned_wb), 32'(exp_mis));
        for (int i = 0; i < GPIO_COUNT; i++) begin
            check($sformatf("gpio_out%0d", i), gpio_out[32*i +: 32], gout_m[i]);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        logic [31:0] by [4];
        logic [31:0] w;
        logic [31:0] v;
        int a, base, off, ho, ch;
        off = int'(addr % 32'd4);
        if (addr[31:8] == 24'hffffff) begin
            ch = int'(addr[7:2]);
            w  = (ch < GPIO_COUNT) ? s2_m[ch] : 32'd0;
            for (int i = 0; i < 4; i++) by[i] = (w / (32'd1 << (8*i))) % 32'd256;
        end else begin
            a    = int'(addr % 32'(MEM_BYTES));
            base = a - a % 4;
            for (int i = 0; i < 4; i++) by[i] = 32'(mb[base + i]);
        end
        case (size)
            2'd0: begin
                v = by[off];
                if (!uns && v >= 32'd128) v = v - 32'd256;
            end
            2'd1: begin
                ho = off - off % 2;
                v  = by[ho] + by[ho + 1] * 32'd256;
                if (!uns && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = by[0] + by[1] * 32'd256 + by[2] * 32'd65536 + by[3] * 32'd16777216;
        endcase
        return v;
    endfunction

    task automatic step(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic rd_we, input logic stall);
        logic [31:0] ld;
        logic        mis, io;
        logic [4:0]  rda;
        logic        rds;
        int ch, a, n, start;
        rda = addr[6:2] ^ data[4:0];
        rds = data[5];
        alu_data_mem       = addr;
        reg_t_data_mem     = data;
        mem_we_mem         = we;
        mem_size_mem       = size;
        mem_unsigned_mem   = uns;
        reg_d_we_mem       = rd_we;
        reg_d_addr_mem     = rda;
        reg_d_data_sel_mem = rds;
        stall_mem          = stall;
        io  = addr[31:8] == 24'hffffff;
        ch  = int'(addr[7:2]);
        mis = (size == 2'd1) ? (addr % 32'd2 != 0) :
              (size >= 2'd2) ? (addr % 32'd4 != 0) : 1'b0;
        ld  = model_load(addr, size, uns);
        if (!stall) begin
            exp_alu  = addr;
            exp_mem  = ld;
            exp_we   = rd_we && !mis;
            exp_addr = rda;
            exp_sel  = rds;
            exp_mis  = mis;
            if (we && !mis) begin
                if (io) begin
                    if (ch < GPIO_COUNT) gout_m[ch] = data;
                end else begin
                    a     = int'(addr % 32'(MEM_BYTES));
                    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
                    start = a - a % n;
                    for (int k = 0; k < n; k++) mb[start + k] = 8'(data >> (8*k));
                end
            end
        end
        for (int i = 0; i < GPIO_COUNT; i++) begin
            s2_m[i] = s1_m[i];
            s1_m[i] = gin[i];
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic stall);
        rst            = 1'b1;
        stall_mem      = stall;
        mem_we_mem     = 1'b1;
        alu_data_mem   = 32'hffff_ff00;
        reg_t_data_mem = 32'hffff_ffff;
        mem_size_mem   = 2'd2;
        exp_alu = '0; exp_mem = '0; exp_we = 1'b0; exp_addr = '0; exp_sel = 1'b0; exp_mis = 1'b0;
        for (int i = 0; i < GPIO_COUNT; i++) begin
            gout_m[i] = '0;
            s1_m[i]   = '0;
            s2_m[i]   = '0;
        end
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  size;
        logic        we, uns, rdw;
        logic [31:0] data;
        int          nstall;

        for (int i = 0; i < GPIO_COUNT; i++) gin[i] = '0;
        mem_unsigned_mem   = 1'b0;
        reg_d_we_mem       = 1'b0;
        reg_d_addr_mem     = '0;
        reg_d_data_sel_mem = 1'b0;
        do_reset(1'b0);

        for (int w = 0; w < 16; w++) step(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, 1'b0);

        // Byte and half loads with sign/zero extension
        step(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, 1'b1, 1'b0);
        step(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0);
        check("lb_0x11", mem_data_wb, 32'hFFFFFFAA);
        step(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0);
        check("lbu_0x11", mem_data_wb, 32'h000000AA);
        step(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0);
        check("lh_0x12", mem_data_wb, 32'hFFFF8899);
        step(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0);
        check("lhu_0x12", mem_data_wb, 32'h00008899);
        step(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345677, 1'b0, 1'b0);
        step(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        check("sb_merge", mem_data_wb, 32'h7799AABB);

        // GPIO writes, out-of-range channel, synchroniser latency
        step(1'b1, 2'd2, 1'b0, 32'hFFFFFF08, 32'hDEADBEEF, 1'b0, 1'b0);
        check("gpio_ch2", gpio_out[95:64], 32'hDEADBEEF);
        check("gpio_ch0", gpio_out[31:0], 32'h0);
        step(1'b1, 2'd2, 1'b0, 32'hFFFFFF40, 32'h11111111, 1'b0, 1'b0);
        step(1'b0, 2'd2, 1'b0, 32'hFFFFFF40, 32'h0, 1'b1, 1'b0);
        check("io_ch16_read", mem_data_wb, 32'h0);
        gin[1] = 32'hA5A5A5A5;
        step(1'b0, 2'd2, 1'b0, 32'hFFFFFF04, 32'h0, 1'b1, 1'b0);
        check("gpio_in_edge1", mem_data_wb, 32'h0);
        step(1'b0, 2'd2, 1'b0, 32'hFFFFFF04, 32'h0, 1'b1, 1'b0);
        check("gpio_in_edge2", mem_data_wb, 32'h0);
        step(1'b0, 2'd2, 1'b0, 32'hFFFFFF04, 32'h0, 1'b1, 1'b0);
        check("gpio_in_edge3", mem_data_wb, 32'hA5A5A5A5);

        // Misaligned stores
        step(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000FFFF, 1'b1, 1'b0);
        check("sh_mis_flag", 32'(misaligned_wb), 32'd1);
        check("sh_mis_we", 32'(reg_d_we_wb), 32'd0);
        step(1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("sw_mis_flag", 32'(misaligned_wb), 32'd1);
        step(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);

        // Stall holds WB and blocks the write until released
        step(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 1'b1, 1'b1);
            check("stall_alu_hold", alu_data_wb, 32'h10);
        end
        step(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 1'b1, 1'b0);
        check("stall_release_alu", alu_data_wb, 32'h30);
        step(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0);
        check("stall_release_write", mem_data_wb, 32'hCAFEF00D);

        // Reset during a stall with gpio_out nonzero
        step(1'b1, 2'd2, 1'b0, 32'h34, 32'h55AA55AA, 1'b1, 1'b1);
        do_reset(1'b1);
        check("reset_gpio_all", gpio_out[31:0] | gpio_out[63:32] | gpio_out[95:64] | gpio_out[127:96], 32'h0);
        step(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        check("reset_mem_kept", mem_data_wb, 32'h7799AABB);
        step(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 1'b1, 1'b0);

        // Random mix of memory/IO traffic, sizes, stalls and input changes
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) == 0) gin[$urandom_range(0, GPIO_COUNT-1)] = $urandom;
            if ($urandom_range(0, 4) == 0)
                addr = {24'hffffff, 6'($urandom_range(0, 7)), 2'($urandom)};
            else
                addr = 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << (ADDR_SIZE + 2));
            size   = 2'($urandom);
            we     = 1'($urandom);
            uns    = 1'($urandom);
            rdw    = 1'($urandom);
            data   = $urandom;
            nstall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            for (int s = 0; s < nstall; s++) step(we, size, uns, addr, data, rdw, 1'b1);
            step(we, size, uns, addr, data, rdw, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
